// File: rtl/d_cache_control.sv
// Control FSM for the 2-way, 8-set LC-3b data cache: hit service, dirty-victim write-back, line fill.
// Optional performance counters are built when D_CACHE_PERF_CNT_EN is defined.
module d_cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 tag_match,
    input  logic                 whichtag,
    input  logic                 valid,
    input  logic                 dirty,
    input  logic                 lru_out,
    output logic                 write0,
    output logic                 write1,
    output logic                 wdirty0,
    output logic                 wdirty1,
    output logic                 dirty0_val,
    output logic                 dirty1_val,
    output logic                 dirty_back,
    output logic                 in_get,
    output logic                 inw1,
    output logic                 inrw1,
    output logic                 load_buf,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_reg;
    logic   hit;
    logic   req;

    assign hit = tag_match & valid;
    assign req = mem_read | mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:      if (req && !hit) state_reg <= dirty ? WRITEBACK : ALLOCATE;
                WRITEBACK: if (pmem_resp) state_reg <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state_reg <= IDLE;
                default:   state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an abandoned transfer drops its handshake at once.
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        write0     = 1'b0;
        write1     = 1'b0;
        wdirty0    = 1'b0;
        wdirty1    = 1'b0;
        dirty0_val = 1'b0;
        dirty1_val = 1'b0;
        dirty_back = 1'b0;
        in_get     = 1'b0;
        inw1       = 1'b0;
        inrw1      = 1'b0;
        load_buf   = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        inrw1    = 1'b1;
                        if (mem_write) begin
                            inw1       = 1'b1;
                            write0     = ~whichtag;
                            write1     = whichtag;
                            wdirty0    = ~whichtag;
                            wdirty1    = whichtag;
                            dirty0_val = ~whichtag;
                            dirty1_val = whichtag;
                        end
                    end else if (req) begin
                        load_buf = 1'b1;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        wdirty0 = ~lru_out;
                        wdirty1 = lru_out;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        write0 = ~lru_out;
                        write1 = lru_out;
                        in_get = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef D_CACHE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]                evt;
    logic [2:0][CNT_WIDTH-1:0] cnt_val;

    assign evt[0] = (state_reg == IDLE) && req && hit;
    assign evt[1] = (state_reg == IDLE) && req && !hit;
    assign evt[2] = (state_reg == WRITEBACK) && pmem_resp;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            // Saturating: holds at all-ones.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg <= '0;
                else if (evt[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + CNT_ONE;
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign hit_count  = cnt_val[0];
    assign miss_count = cnt_val[1];
    assign wb_count   = cnt_val[2];
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_d_cache_control.sv
// Randomized transaction-level bench for d_cache_control: each request is expanded into its expected
// per-cycle output trace (hit, or miss with optional write-back and fill) and compared cycle by cycle.
module tb_d_cache_control;

    localparam int CW  = 2;
    localparam int CAP = (1 << CW) - 1;

    localparam logic [13:0] O_RESP   = 14'h2000;
    localparam logic [13:0] O_PREAD  = 14'h1000;
    localparam logic [13:0] O_PWRITE = 14'h0800;
    localparam logic [13:0] O_W0     = 14'h0400;
    localparam logic [13:0] O_W1     = 14'h0200;
    localparam logic [13:0] O_WD0    = 14'h0100;
    localparam logic [13:0] O_WD1    = 14'h0080;
    localparam logic [13:0] O_D0V    = 14'h0040;
    localparam logic [13:0] O_D1V    = 14'h0020;
    localparam logic [13:0] O_INGET  = 14'h0008;
    localparam logic [13:0] O_INW1   = 14'h0004;
    localparam logic [13:0] O_INRW1  = 14'h0002;
    localparam logic [13:0] O_LOAD   = 14'h0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic tag_match = 1'b0, whichtag = 1'b0, valid = 1'b0, dirty = 1'b0, lru_out = 1'b0;
    logic mem_resp, pmem_read, pmem_write, write0, write1, wdirty0, wdirty1;
    logic dirty0_val, dirty1_val, dirty_back, in_get, inw1, inrw1, load_buf;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int total = 0;
    int bad = 0;
    int m_hits = 0, m_misses = 0, m_wbs = 0;

    always #5 clk = ~clk;

    d_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .tag_match(tag_match), .whichtag(whichtag), .valid(valid), .dirty(dirty), .lru_out(lru_out),
        .write0(write0), .write1(write1), .wdirty0(wdirty0), .wdirty1(wdirty1),
        .dirty0_val(dirty0_val), .dirty1_val(dirty1_val), .dirty_back(dirty_back),
        .in_get(in_get), .inw1(inw1), .inrw1(inrw1), .load_buf(load_buf),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    wire logic [13:0] outs = {mem_resp, pmem_read, pmem_write, write0, write1, wdirty0, wdirty1,
                              dirty0_val, dirty1_val, dirty_back, in_get, inw1, inrw1, load_buf};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] inp(input bit rd, input bit wr, input bit resp, input bit tm,
                                       input bit wt, input bit vl, input bit dt, input bit lru);
        return {rd, wr, resp, tm, wt, vl, dt, lru};
    endfunction

    function automatic logic [13:0] hit_exp(input bit wr, input bit way);
        logic [13:0] e;
        e = O_RESP | O_INRW1;
        if (wr) e |= O_INW1 | (way ? (O_W1 | O_WD1 | O_D1V) : (O_W0 | O_WD0 | O_D0V));
        return e;
    endfunction

    // One clock cycle: apply inputs, check outputs and counters, advance the counter model.
    task automatic step(input string tag, input bit rst_v, input logic [7:0] in_v, input logic [13:0] exp_v);
        reset = rst_v;
        {mem_read, mem_write, pmem_resp, tag_match, whichtag, valid, dirty, lru_out} = in_v;
        #1;
        chk(tag, 32'(outs), 32'(exp_v));
        if (rst_v) begin
            m_hits = 0; m_misses = 0; m_wbs = 0;
        end
`ifdef D_CACHE_PERF_CNT_EN
        chk("hit_count", 32'(hit_count), m_hits);
        chk("miss_count", 32'(miss_count), m_misses);
        chk("wb_count", 32'(wb_count), m_wbs);
`else
        chk("counters_zero", 32'({hit_count, miss_count, wb_count}), 0);
`endif
        if (!rst_v) begin
            if ((exp_v & O_RESP) != 0 && m_hits < CAP) m_hits++;
            if ((exp_v & O_LOAD) != 0 && m_misses < CAP) m_misses++;
            if ((exp_v & O_PWRITE) != 0 && in_v[5] && m_wbs < CAP) m_wbs++;
        end
        @(posedge clk);
        #1;
    endtask

    // Full CPU request: a hit, or a miss with optional write-back, fill and the final serving hit.
    task automatic run_txn(input int id, input bit rd_i, input bit wr_i, input bit hit_i, input bit dty,
                           input bit lru, input bit way, input int wb_lat, input int fill_lat,
                           input int drop_at);
        bit rd, wr, tm, vl, resp;
        rd = rd_i;
        wr = wr_i;
        $display("txn %0d rd=%0b wr=%0b hit=%0b dirty=%0b lru=%0b way=%0b wb=%0d fill=%0d drop=%0d",
                 id, rd, wr, hit_i, dty, lru, way, wb_lat, fill_lat, drop_at);
        if (hit_i) begin
            step("hit", 1'b0, inp(rd, wr, rb(), 1'b1, way, 1'b1, rb(), rb()), hit_exp(wr, way));
            return;
        end
        tm = rb();
        vl = tm ? 1'b0 : rb();
        step("miss", 1'b0, inp(rd, wr, rb(), tm, rb(), vl, dty, lru), O_LOAD);
        if (dty) begin
            for (int i = 1; i <= wb_lat; i++) begin
                resp = (i == wb_lat);
                step("writeback", 1'b0, inp(rd, wr, resp, rb(), rb(), rb(), rb(), lru),
                     O_PWRITE | (resp ? (lru ? O_WD1 : O_WD0) : 14'h0));
            end
        end
        for (int i = 1; i <= fill_lat; i++) begin
            if (i == drop_at) begin
                rd = 1'b0;
                wr = 1'b0;
            end
            resp = (i == fill_lat);
            step("fill", 1'b0, inp(rd, wr, resp, rb(), rb(), rb(), rb(), lru),
                 O_PREAD | (resp ? ((lru ? O_W1 : O_W0) | O_INGET) : 14'h0));
        end
        if (rd | wr)
            step("miss_done", 1'b0, inp(rd, wr, 1'b0, 1'b1, lru, 1'b1, rb(), lru), hit_exp(wr, lru));
        else
            step("withdrawn", 1'b0, inp(1'b0, 1'b0, 1'b0, 1'b1, lru, 1'b1, rb(), lru), 14'h0);
    endtask

    initial begin
        int kind;
        @(posedge clk);
        #1;
        step("reset_outputs", 1'b1, inp(1, 0, 0, 1, 0, 1, 0, 0), 14'h0);
        step("first_read_hit", 1'b0, inp(1, 0, 0, 1, 0, 1, 0, 0), O_RESP | O_INRW1);

        run_txn(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        run_txn(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 0);
        run_txn(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 4, 0);
        run_txn(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Reset on the second fill cycle, then a stray pmem_resp in IDLE.
        step("rst_miss", 1'b0, inp(1, 0, 0, 0, 0, 0, 0, 0), O_LOAD);
        step("rst_fill1", 1'b0, inp(1, 0, 0, 0, 0, 0, 0, 0), O_PREAD);
        step("rst_mid_fill", 1'b1, inp(1, 0, 1, 0, 0, 0, 0, 0), 14'h0);
        step("idle_pmem_resp", 1'b0, inp(0, 0, 1, 0, 0, 0, 1, 1), 14'h0);
        step("after_rst_miss", 1'b0, inp(0, 1, 0, 0, 0, 0, 0, 1), O_LOAD);
        step("after_rst_fill", 1'b0, inp(0, 1, 1, 0, 0, 0, 0, 1), O_PREAD | O_W1 | O_INGET);
        step("after_rst_hit", 1'b0, inp(0, 1, 0, 1, 1, 1, 0, 1), hit_exp(1'b1, 1'b1));

        run_txn(5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 4, 2);

        for (int i = 0; i < 4; i++)
            run_txn(10 + i, 1'b1, 1'b0, 1'b0, 1'b1, i[0], 1'b0, 2, 2, 0);
        run_txn(14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run_txn(15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);

        step("sat_reset", 1'b1, inp(0, 0, 0, 0, 0, 0, 0, 0), 14'h0);
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            run_txn(100 + i, kind != 1, kind != 0, $urandom_range(0, 2) == 0, rb(), rb(), rb(),
                    $urandom_range(1, 6), $urandom_range(1, 6),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
        end
        step("final_idle", 1'b0, inp(0, 0, 0, 0, 0, 0, 0, 0), 14'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_cache_control.md
Name: d_cache_control

Overview:
- Control FSM for the 2-way, 8-set, 128-bit-line LC-3b data cache datapath.
- Decodes CPU requests (mem_read/mem_write) against the datapath status signals (tag_match, whichtag, valid, dirty, lru_out).
- Drives the datapath array-write, mux-select and dirty controls, and the physical-memory handshake.
- Handles write-back of a dirty victim line and allocation of the missing line; sits between the CPU memory port, d_cache_datapath and physical memory.

Parameters:
- CNT_WIDTH, 16, width of each performance counter (used only when D_CACHE_PERF_CNT_EN is defined).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  CPU read request, held until mem_resp.
- mem_write  input  1  CPU write request, held until mem_resp.
- mem_resp  output  1  request complete, one-cycle pulse.
- pmem_resp  input  1  physical memory transfer done, one-cycle pulse.
- pmem_read  output  1  line fill request.
- pmem_write  output  1  line write-back request; also the datapath pmem_address mux select.
- tag_match  input  1  a way's tag matches.
- whichtag  input  1  matching way index.
- valid  input  1  valid bit of the matching way.
- dirty  input  1  dirty bit of the LRU way.
- lru_out  input  1  LRU (victim) way for the current index.
- write0, write1  output  1 each  tag/data/valid array write for way 0/1.
- wdirty0, wdirty1  output  1 each  dirty array write for way 0/1.
- dirty0_val, dirty1_val  output  1 each  dirty data when in_get=0.
- dirty_back  output  1  dirty data when in_get=1.
- in_get  output  1  line-fill in progress (selects dirty_back, enables dirty write with writeX).
- inw1  output  1  data mux: 0=pmem_rdata, 1=write_calc merge.
- inrw1  output  1  LRU array write (LRU := other way of hit).
- load_buf  output  1  capture lru_out into lru_buffer.
- hit_count, miss_count, wb_count  output  CNT_WIDTH each  performance counters.

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. State register only; all outputs are combinational from state and inputs.
- Reset: state := IDLE asynchronously. While reset=1 every output is 0 regardless of inputs. A reset asserted mid-WRITEBACK or mid-ALLOCATE drops pmem_read/pmem_write immediately; the partial transfer is abandoned and no array write occurs.
- Default: every output not named below is 0 in every state.
- hit = tag_match & valid. Request = mem_read | mem_write. If both are high, the access is treated as a write.
- IDLE, no request: all outputs 0; stay in IDLE.
- IDLE, read hit:
  - mem_resp=1 and inrw1=1 in the same cycle (zero-wait hit); stay in IDLE.
- IDLE, write hit, way w = whichtag:
  - write_w=1, inw1=1, wdirty_w=1, dirty_w_val=1, inrw1=1, mem_resp=1; stay in IDLE.
- IDLE, miss: load_buf=1, mem_resp=0.
  - Next state WRITEBACK if dirty=1, else ALLOCATE.
- WRITEBACK:
  - pmem_write=1 until pmem_resp.
  - On the pmem_resp cycle: wdirty_v=1 and dirty_v_val=0 (v = lru_out); next state ALLOCATE.
- ALLOCATE:
  - pmem_read=1 until pmem_resp.
  - On the pmem_resp cycle: write_v=1, inw1=0, in_get=1, dirty_back=0 (v = lru_out); next state IDLE.
- Miss completion: the returning IDLE cycle re-evaluates, hits, and serves the request (a write merges into the freshly filled line).
- lru_out is stable through a miss (inrw1 is never asserted outside IDLE), so the victim way is consistent across WRITEBACK and ALLOCATE.
- Request withdrawn mid-miss: the FSM completes the write-back/fill anyway and returns to IDLE; no mem_resp is issued.
- pmem_resp while in IDLE: ignored.
- mem_resp is never asserted outside IDLE.
- Miss latency: clean miss = fill cycles + 1; dirty miss = write-back cycles + fill cycles + 1.

Optional Feature:
- Macro D_CACHE_PERF_CNT_EN.
- Defined: hit_count, miss_count and wb_count are CNT_WIDTH-bit saturating counters, reset to 0 asynchronously.
  - hit_count increments on each IDLE cycle with a request and hit=1, so a miss's final hit also counts.
  - miss_count increments on each IDLE→(WRITEBACK|ALLOCATE) transition.
  - wb_count increments on each WRITEBACK→ALLOCATE transition.
  - Each counter holds at all-ones.
- Undefined: all three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset with mem_read=1, tag_match=1, valid=1 -> all outputs 0; after release, same cycle mem_resp=1, inrw1=1.
- Write hit, whichtag=1 -> single cycle with write1=1, inw1=1, wdirty1=1, dirty1_val=1, inrw1=1, mem_resp=1; write0=0.
- Clean read miss, lru_out=0, dirty=0, pmem_resp after 5 cycles -> load_buf=1 in IDLE; pmem_read=1 for 5 cycles; write0=1, in_get=1, dirty_back=0 on the resp cycle; mem_resp=1 the following cycle (hit).
- Dirty write miss, lru_out=1, dirty=1 -> pmem_write=1 until resp; wdirty1=1, dirty1_val=0 on resp; then pmem_read=1 until resp; write1=1; then write hit with inw1=1, mem_resp=1.
- Reset asserted on the 2nd ALLOCATE cycle -> pmem_read falls immediately, state IDLE, no array write; mem_read withdrawn mid-fill -> no mem_resp.
- With D_CACHE_PERF_CNT_EN and CNT_WIDTH=2: 4 dirty misses -> miss_count=3, wb_count=3 (saturated); 2 read hits -> hit_count=3.
